md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have port: reset  input  1  reset; synchronous and active-low (0 = reset, sampled on rising edge of clk).
REQ-003 The block SHALL have port: a  input  32  E-stage rs operand, already bypass-selected (post rse_sel mux).
REQ-004 The block SHALL have port: b  input  32  E-stage rt operand, already bypass-selected (post rte_sel mux).
REQ-005 The block SHALL have port: md_op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 The block SHALL have port: start  input  1  qualifier; md_op acted on only in a cycle with start=1.
REQ-007 The block SHALL have port: busy  output  1  high while a multiply/divide is in progress (registered).
REQ-008 The block SHALL have port: hi  output  32  HI register (registered).
REQ-009 The block SHALL have port: lo  output  32  LO register (registered).

Function
REQ-010 The block SHALL implement states IDLE, MUL and DIV, plus a 4-bit countdown counter.
REQ-011 IDLE + start + md_op in {1,2} SHALL: latch a/b and op, load counter=5, go to MUL.
REQ-012 IDLE + start + md_op in {3,4} SHALL: latch a/b and op, load counter=10, go to DIV.
REQ-013 In MUL/DIV, the counter SHALL decrement once per cycle.
REQ-014 When the counter reaches 1, the block SHALL on that edge write the result to hi/lo and return to IDLE.
REQ-015 Timing, start sampled at edge of cycle T: busy=1 in cycles T+1..T+5 (mult) or T+1..T+10 (div); new hi/lo visible from T+6 / T+11; busy=0 in that same cycle.
REQ-016 mult SHALL compute the signed 32x32 product: {hi,lo} = 64-bit two's-complement product.
REQ-017 multu SHALL compute the unsigned 32x32 product: {hi,lo} = 64-bit unsigned product.
REQ-018 div SHALL compute signed division: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (a).
REQ-019 div with a=0x80000000, b=0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-020 divu SHALL compute unsigned division: lo = a/b, hi = a%b.
REQ-021 Division by zero (latched b=0) SHALL run the full 10 cycles and leave hi/lo unchanged.
REQ-022 Operands SHALL be latched at start; changes on a/b during busy SHALL NOT affect the result.
REQ-023 In IDLE, mthi (start, md_op=5) SHALL set hi=a on the same edge; busy stays 0; lo unchanged.
REQ-024 In IDLE, mtlo (start, md_op=6) SHALL set lo=a on the same edge; busy stays 0; hi unchanged.
REQ-025 Any start while busy=1 (any md_op) SHALL be ignored: no state, counter, hi or lo change.
REQ-026 Any start with md_op in {0,7} SHALL be ignored.
REQ-027 hi/lo SHALL hold their value in every cycle not covered by REQ-014, REQ-023 or REQ-024.
REQ-028 hi/lo SHALL hold their old value throughout busy (readable by mfhi/mflo; the stall unit holds mfhi/mflo while start|busy).

Reset
REQ-029 On reset=0 at a rising edge, the block SHALL set: state=IDLE, counter=0, busy=0, hi=0x00000000, lo=0x00000000, latched operands=0.
REQ-030 Reset mid-operation SHALL abort the operation; no partial or final result SHALL be written.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification
REQ-032 The bench SHALL apply: mult, a=0xFFFFFFFE (-2), b=3 at T -> busy=1 T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+6.
REQ-033 The bench SHALL apply: multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-034 The bench SHALL apply: div, a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-035 The bench SHALL apply: mthi a=0x12345678, next cycle divu a=5, b=0 -> hi=0x12345678 after 1 edge, busy 10 cycles, hi/lo unchanged afterwards.
REQ-036 The bench SHALL apply: divu a=100, b=7, then at T+3 start mtlo a=0xAAAA and drive a=0 -> mtlo ignored; lo=14, hi=2 at T+11.
REQ-037 The bench SHALL apply: mult started, reset=0 at T+2 -> busy=0, hi=lo=0 from T+3; no later write.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit: fixed-latency mult/multu (5 cycles) and div/divu (10 cycles)
// writing HI/LO, plus single-cycle mthi/mtlo. o_dbg_state exposes the FSM state.
module md_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  md_op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [2:0]  r_op;

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [63:0] w_prod;
   logic        w_div_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_b_zero;

   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
   assign w_prod   = (r_op == OP_MULTU) ? w_prod_u : w_prod_s;

   // Signed division on magnitudes: 0x80000000 / -1 then falls out naturally as 0x80000000.
   assign w_div_signed = (r_op == OP_DIV);
   assign w_a_neg      = w_div_signed & r_a[31];
   assign w_b_neg      = w_div_signed & r_b[31];
   assign w_a_mag      = w_a_neg ? (~r_a + 32'd1) : r_a;
   assign w_b_mag      = w_b_neg ? (~r_b + 32'd1) : r_b;
   assign w_b_zero     = (r_b == 32'd0);
   assign w_q_mag      = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
   assign w_r_mag      = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
   assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 3'd0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (md_op)
                     OP_MULT, OP_MULTU: begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= md_op;
                        r_cnt   <= 4'd5;
                        r_state <= S_MUL;
                        busy    <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= md_op;
                        r_cnt   <= 4'd10;
                        r_state <= S_DIV;
                        busy    <= 1'b1;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               if (r_cnt == 4'd1) begin
                  if (r_state == S_MUL) begin
                     hi <= w_prod[63:32];
                     lo <= w_prod[31:0];
                  end else if (!w_b_zero) begin
                     hi <= w_rem;
                     lo <= w_quot;
                  end
                  r_cnt   <= 4'd0;
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: an arithmetic reference model checked every cycle,
// plus literal expectations taken from hand-worked examples.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  md_op;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   md_unit dut (
      .clk         (clk),
      .reset       (reset),
      .a           (a),
      .b           (b),
      .md_op       (md_op),
      .start       (start),
      .busy        (busy),
      .hi          (hi),
      .lo          (lo),
      .o_dbg_state (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: cycles left in the current operation and the result it will deliver.
   int          m_left  = 0;
   bit          m_write = 1'b0;
   logic [31:0] m_nhi   = 32'd0;
   logic [31:0] m_nlo   = 32'd0;
   logic [31:0] m_hi    = 32'd0;
   logic [31:0] m_lo    = 32'd0;

   task automatic model_step();
      longint sa, sb, q, r, ps;
      logic [63:0] pu;
      if (!reset) begin
         m_left  = 0;
         m_write = 1'b0;
         m_hi    = 32'd0;
         m_lo    = 32'd0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_write) begin
            m_hi = m_nhi;
            m_lo = m_nlo;
         end
      end else if (start) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         case (md_op)
            3'd1: begin
               ps = sa * sb;
               m_nhi = ps[63:32]; m_nlo = ps[31:0];
               m_write = 1'b1; m_left = 5;
            end
            3'd2: begin
               pu = {32'd0, a} * {32'd0, b};
               m_nhi = pu[63:32]; m_nlo = pu[31:0];
               m_write = 1'b1; m_left = 5;
            end
            3'd3: begin
               m_write = (b != 32'd0); m_left = 10;
               if (m_write) begin
                  q = sa / sb; r = sa % sb;
                  m_nlo = q[31:0]; m_nhi = r[31:0];
               end
            end
            3'd4: begin
               m_write = (b != 32'd0); m_left = 10;
               if (m_write) begin
                  m_nlo = a / b; m_nhi = a % b;
               end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
         endcase
      end
   endtask

   // Scoreboard compare: every cycle, just after the active edge.
   always @(posedge clk) begin
      model_step();
      #1;
      chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
   end

   // Driver tasks: called at a negedge, return at a negedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb);
      a = aa; b = bb; md_op = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [31:0] aa,
                      input logic [31:0] bb, input int exp_cycles,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      issue(op, aa, bb);
      a = $urandom_range(0, 32'hFFFF); b = $urandom_range(0, 32'hFFFF);
      count_busy(n);
      chk({name, "_cycles"}, n, exp_cycles);
      chk({name, "_hi"}, hi, exp_hi);
      chk({name, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run("mult_neg2x3", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
      run("mult_minmin", 3'd1, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);
      run("div_neg7by2", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run("div_7byneg2", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
      run("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

      // mthi then divide-by-zero on the next cycle
      issue(3'd5, 32'h12345678, 32'd0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      run("divu_by0", 3'd4, 32'd5, 32'd0, 10, 32'h12345678, 32'h80000000);

      // mtlo during a busy divu is ignored; operand changes do not leak in
      issue(3'd4, 32'd100, 32'd7);
      @(negedge clk);
      @(negedge clk);
      a = 32'h0000AAAA; md_op = 3'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
      count_busy(n);
      chk("divu_mtlo_cycles", n, 7);
      chk("divu_mtlo_hi", hi, 32'd2);
      chk("divu_mtlo_lo", lo, 32'd14);

      // md_op 0 and 7 are ignored
      issue(3'd6, 32'h00000011, 32'd0);
      issue(3'd0, 32'h00000099, 32'd1);
      issue(3'd7, 32'h00000077, 32'd1);
      chk("nop_busy", {31'd0, busy}, 32'd0);
      chk("nop_hi", hi, 32'd2);
      chk("nop_lo", lo, 32'h00000011);

      // reset in the middle of a multiply aborts it
      issue(3'd1, 32'd5, 32'd6);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      repeat (8) @(negedge clk);
      chk("abort_later_hi", hi, 32'd0);
      chk("abort_later_lo", lo, 32'd0);

      // reset wins over a simultaneous start
      issue(3'd5, 32'hCAFE0001, 32'd0);
      reset = 1'b0; a = 32'd3; b = 32'd3; md_op = 3'd1; start = 1'b1;
      @(negedge clk);
      reset = 1'b1; start = 1'b0; md_op = 3'd0;
      chk("rstprio_busy", {31'd0, busy}, 32'd0);
      chk("rstprio_hi", hi, 32'd0);
      repeat (7) @(negedge clk);
      chk("rstprio_later_lo", lo, 32'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
